// File: rtl/nic_pwr_slot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// nic_pwr_slot_arbiter_pkg
//   Shared definitions for the NIC power sequencing blocks. Contains:
//   - the arbiter state encoding, which is also driven onto the debug port
//   - the default delay constants in milliseconds
// -----------------------------------------------------------------------------
package nic_pwr_slot_arbiter_pkg;

    // Width of the arbiter state encoding and of the debug port that mirrors it.
    localparam int ARB_STATE_W = 4;

    // Default delays in milliseconds.
    localparam int PG_TIMEOUT_MS_DFLT = 1050;  // grant -> power-good limit
    localparam int STAGGER_MS_DFLT    = 21;    // minimum spacing between grants

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE    = 4'h0,
        ARB_GRANT   = 4'h1,
        ARB_WAIT_PG = 4'h2,
        ARB_SPACE   = 4'h3
    } arb_state_e;

endpackage : nic_pwr_slot_arbiter_pkg

// File: rtl/nic_pwr_slot_arbiter_ms_counter.sv
// -----------------------------------------------------------------------------
// nic_ms_counter
//   Millisecond delay counter. Counts tick strobes, saturates at all-ones and
//   flags when the count has reached a compare value.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset, count -> 0
//   clr      in   synchronous clear, count -> 0 (wins over tick)
//   tick     in   count enable, one strobe per millisecond
//   cmp_val  in   compare value
//   count    out  current count
//   hit      out  count >= cmp_val
// -----------------------------------------------------------------------------
module nic_ms_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] cmp_val,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick && (count_q != {CNT_W{1'b1}})) begin
            // Hold at all-ones instead of wrapping back to zero.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // ">=" so a saturated counter still reports the limit as reached.
    assign hit   = (count_q >= cmp_val);

endmodule : nic_ms_counter

// File: rtl/nic_pwr_slot_arbiter.sv
// -----------------------------------------------------------------------------
// nic_pwr_slot_arbiter
//   Grants main-power enable to OCP3 NIC slots one at a time, in round-robin
//   order, with a minimum spacing between grants to limit inrush current.
//   After each grant it waits for the slot's power-good. A slot that does not
//   reach power-good in time gets a sticky fault and loses its grant.
//
// Ports
//   iClk          in   module clock
//   iRst          in   synchronous active-high reset
//   iTick_1ms     in   one-cycle strobe every millisecond
//   iPRSNT_N      in   [NUM_SLOTS] presence, low = card present
//   iREQ          in   [NUM_SLOTS] level request for main power
//   iPWRGD        in   [NUM_SLOTS] main power-good
//   iFLT_CLR      in   pulse that clears all sticky faults
//   oGNT          out  [NUM_SLOTS] main power enable permission
//   oFLT          out  [NUM_SLOTS] sticky power-good timeout fault
//   oDBG_ARB_FSM  out  [4] current arbiter state
// -----------------------------------------------------------------------------
module nic_pwr_slot_arbiter
    import nic_pwr_slot_arbiter_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int PG_TIMEOUT_MS = PG_TIMEOUT_MS_DFLT,
    parameter int STAGGER_MS    = STAGGER_MS_DFLT,
    parameter int CNT_W         = 16
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iTick_1ms,
    input  logic [NUM_SLOTS-1:0]   iPRSNT_N,
    input  logic [NUM_SLOTS-1:0]   iREQ,
    input  logic [NUM_SLOTS-1:0]   iPWRGD,
    input  logic                   iFLT_CLR,
    output logic [NUM_SLOTS-1:0]   oGNT,
    output logic [NUM_SLOTS-1:0]   oFLT,
    output logic [ARB_STATE_W-1:0] oDBG_ARB_FSM
);

    localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    arb_state_e           state_q,  state_d;
    logic [SEL_W-1:0]     sel_q,    sel_d;
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_SLOTS-1:0] gnt_q,    gnt_d;
    logic [NUM_SLOTS-1:0] flt_q,    flt_d;

    logic [NUM_SLOTS-1:0] keep;
    logic [NUM_SLOTS-1:0] eligible;
    logic                 pick_valid;
    logic [SEL_W-1:0]     pick_idx;
    int                   cand;

    logic                 cnt_clr;
    logic [CNT_W-1:0]     cnt_cmp;
    logic [CNT_W-1:0]     cnt_val;
    logic                 cnt_hit;

    // A slot may hold a grant only while it is present and still requesting.
    assign keep     = iREQ & ~iPRSNT_N;
    assign eligible = keep & ~gnt_q & ~flt_q;

    // Round-robin pick: search starts one past the last granted slot.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int off = 1; off <= NUM_SLOTS; off++) begin
            cand = (int'(rr_ptr_q) + off) % NUM_SLOTS;
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = SEL_W'(cand);
            end
        end
    end

    // One counter serves both the power-good timeout and the stagger window.
    assign cnt_cmp = (state_q == ARB_SPACE) ? CNT_W'(STAGGER_MS) : CNT_W'(PG_TIMEOUT_MS);

    nic_ms_counter #(
        .CNT_W (CNT_W)
    ) u_ms_counter (
        .clk     (iClk),
        .rst     (iRst),
        .clr     (cnt_clr),
        .tick    (iTick_1ms),
        .cmp_val (cnt_cmp),
        .count   (cnt_val),
        .hit     (cnt_hit)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        cnt_clr  = 1'b0;
        // Grants fall one cycle after a request drop or card removal, in any state.
        gnt_d    = gnt_q & keep;
        // Clear first so a timeout on the same cycle can still set its bit.
        flt_d    = iFLT_CLR ? '0 : flt_q;

        case (state_q)
            ARB_IDLE: begin
                cnt_clr = 1'b1;
                if (pick_valid) begin
                    sel_d    = pick_idx;
                    rr_ptr_d = pick_idx;
                    state_d  = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                cnt_clr = 1'b1;
                // If the slot dropped since it was picked, no grant is raised;
                // WAIT_PG then sees the drop and moves on without a fault.
                gnt_d[sel_q] = keep[sel_q];
                state_d      = ARB_WAIT_PG;
            end

            ARB_WAIT_PG: begin
                if (!keep[sel_q]) begin
                    cnt_clr = 1'b1;
                    state_d = ARB_SPACE;
                end else if (iPWRGD[sel_q]) begin
                    // Checked before the timeout so power-good wins a tie.
                    cnt_clr = 1'b1;
                    state_d = ARB_SPACE;
                end else if (cnt_hit) begin
                    flt_d[sel_q] = 1'b1;
                    gnt_d[sel_q] = 1'b0;
                    cnt_clr      = 1'b1;
                    state_d      = ARB_SPACE;
                end
            end

            ARB_SPACE: begin
                if (cnt_hit) begin
                    cnt_clr = 1'b1;
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                cnt_clr = 1'b1;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= ARB_IDLE;
            sel_q    <= '0;
            // Pointer parked on the last slot so slot 0 is searched first.
            rr_ptr_q <= SEL_W'(NUM_SLOTS - 1);
            gnt_q    <= '0;
            flt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            flt_q    <= flt_d;
        end
    end

    assign oGNT         = gnt_q;
    assign oFLT         = flt_q;
    assign oDBG_ARB_FSM = state_q;

endmodule : nic_pwr_slot_arbiter

// File: tb/tb_nic_pwr_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nic_pwr_slot_arbiter
//   Directed bench for nic_pwr_slot_arbiter with default parameters
//   (4 slots, 1050 ms timeout, 21 ms stagger). A millisecond is modelled as
//   three clock cycles with the tick strobe high in the first one.
// -----------------------------------------------------------------------------
module tb_nic_pwr_slot_arbiter;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] prsnt_n;
    logic [3:0] req;
    logic [3:0] pwrgd;
    logic       flt_clr;
    logic [3:0] gnt;
    logic [3:0] flt;
    logic [3:0] dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q[$];

    nic_pwr_slot_arbiter dut (
        .iClk         (clk),
        .iRst         (rst),
        .iTick_1ms    (tick),
        .iPRSNT_N     (prsnt_n),
        .iREQ         (req),
        .iPWRGD       (pwrgd),
        .iFLT_CLR     (flt_clr),
        .oGNT         (gnt),
        .oFLT         (flt),
        .oDBG_ARB_FSM (dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_ms(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
            cyc();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops the next expected grant vector from the queue.
    task automatic chk_gnt_q(input string tag);
        logic [3:0] e;
        e = exp_q.pop_front();
        chk(tag, gnt, e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        tick    = 1'b0;
        prsnt_n = 4'hF;
        req     = 4'h0;
        pwrgd   = 4'h0;
        flt_clr = 1'b0;
        cyc();
        cyc();
        chk("reset_gnt", gnt, 4'h0);
        chk("reset_flt", flt, 4'h0);
        chk("reset_state", dbg, 4'h0);
        rst     = 1'b0;
        prsnt_n = 4'h0;
        cyc();
        tick_ms(2);
        chk("idle_tick_no_effect", dbg, 4'h0);

        // ---- slots 0 and 2 request together ----
        req = 4'b0101;
        cyc();
        chk("a_grant_state", dbg, 4'h1);
        chk("a_gnt_not_yet", gnt, 4'b0000);
        cyc();
        chk("a_gnt0_first", gnt, 4'b0001);
        chk("a_wait_pg", dbg, 4'h2);
        tick_ms(3);
        pwrgd = 4'b0001;
        cyc();
        chk("a_space", dbg, 4'h3);
        tick_ms(20);
        chk("a_still_space_20ms", dbg, 4'h3);
        chk("a_gnt2_held_off", gnt, 4'b0001);
        tick_ms(1);
        chk("a_grant2_state", dbg, 4'h1);
        cyc();
        chk("a_gnt2", gnt, 4'b0101);
        pwrgd = 4'b0101;
        cyc();
        tick_ms(21);
        chk("a_back_idle", dbg, 4'h0);

        // ---- slot 1 times out ----
        req = 4'b0111;
        cyc();
        cyc();
        chk("b_gnt1", gnt, 4'b0111);
        tick_ms(1049);
        chk("b_no_flt_1049", flt, 4'b0000);
        chk("b_gnt_1049", gnt, 4'b0111);
        tick_ms(1);
        chk("b_flt1", flt, 4'b0010);
        chk("b_gnt1_dropped", gnt, 4'b0101);
        chk("b_space", dbg, 4'h3);
        tick_ms(21);
        chk("b_idle_faulted", dbg, 4'h0);
        tick_ms(2);
        chk("b_ignored", dbg, 4'h0);
        chk("b_ignored_gnt", gnt, 4'b0101);
        flt_clr = 1'b1;
        cyc();
        flt_clr = 1'b0;
        chk("b_flt_cleared", flt, 4'b0000);
        cyc();
        cyc();
        chk("b_regrant", gnt, 4'b0111);
        pwrgd = 4'b0111;
        cyc();
        tick_ms(21);

        // ---- all four request continuously ----
        req   = 4'h0;
        pwrgd = 4'h0;
        rst   = 1'b1;
        cyc();
        rst   = 1'b0;
        exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1111};
        req   = 4'b1111;
        cyc();
        cyc();
        chk_gnt_q("c_order0");
        pwrgd = 4'b0001;
        cyc();
        tick_ms(21);
        cyc();
        chk_gnt_q("c_order1");
        pwrgd = 4'b0011;
        cyc();
        tick_ms(21);
        cyc();
        chk_gnt_q("c_order2");
        req = 4'b1110;
        cyc();
        chk("c_drop0", gnt, 4'b0110);
        req   = 4'b1111;
        pwrgd = 4'b0110;
        cyc();
        tick_ms(21);
        cyc();
        chk_gnt_q("c_order3");
        pwrgd = 4'b1110;
        cyc();
        tick_ms(21);
        cyc();
        chk_gnt_q("c_slot0_after3");
        pwrgd = 4'b1111;
        cyc();
        tick_ms(21);
        chk("c_idle", dbg, 4'h0);

        // ---- slot 3 drops 5 ms into WAIT_PG ----
        req   = 4'h0;
        pwrgd = 4'h0;
        cyc();
        chk("d_all_dropped", gnt, 4'b0000);
        req = 4'b1000;
        cyc();
        cyc();
        chk("d_gnt3", gnt, 4'b1000);
        tick_ms(5);
        req = 4'b0000;
        cyc();
        chk("d_gnt3_off", gnt, 4'b0000);
        chk("d_no_flt", flt, 4'b0000);
        chk("d_space", dbg, 4'h3);
        tick_ms(20);
        chk("d_space_20ms", dbg, 4'h3);
        tick_ms(1);
        chk("d_idle_21ms", dbg, 4'h0);

        // ---- power-good coincides with timeout ----
        req = 4'b0100;
        cyc();
        cyc();
        chk("e_gnt2", gnt, 4'b0100);
        tick_ms(1049);
        tick = 1'b1;
        cyc();
        tick  = 1'b0;
        pwrgd = 4'b0100;
        cyc();
        chk("e_pg_wins_flt", flt, 4'b0000);
        chk("e_pg_wins_gnt", gnt, 4'b0100);
        chk("e_pg_wins_state", dbg, 4'h3);
        tick_ms(21);
        req   = 4'h0;
        pwrgd = 4'h0;
        cyc();

        // ---- fault clear coincides with timeout ----
        req = 4'b0100;
        cyc();
        cyc();
        tick_ms(1049);
        tick = 1'b1;
        cyc();
        tick    = 1'b0;
        flt_clr = 1'b1;
        cyc();
        flt_clr = 1'b0;
        chk("e_set_wins_flt", flt, 4'b0100);
        chk("e_set_wins_gnt", gnt, 4'b0000);
        tick_ms(21);
        chk("e_faulted_idle", dbg, 4'h0);
        flt_clr = 1'b1;
        cyc();
        flt_clr = 1'b0;
        req     = 4'h0;
        chk("e_flt_clr", flt, 4'b0000);

        // ---- reset during WAIT_PG with two grants active ----
        req = 4'b0101;
        cyc();
        cyc();
        chk("f_gnt0", gnt, 4'b0001);
        pwrgd = 4'b0001;
        cyc();
        tick_ms(21);
        cyc();
        chk("f_gnt_0101", gnt, 4'b0101);
        chk("f_wait_pg", dbg, 4'h2);
        rst = 1'b1;
        cyc();
        chk("f_reset_gnt", gnt, 4'b0000);
        chk("f_reset_state", dbg, 4'h0);
        rst = 1'b0;
        cyc();
        cyc();
        chk("f_regrant_2cyc", gnt, 4'b0001);
        chk("f_regrant_state", dbg, 4'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nic_pwr_slot_arbiter
